load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DataWidth, default 32, giving the data/address width (behaviour below is specified for 32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port valid_in, input, 1, execute-stage result valid.
REQ-005 SHALL have port ready_out, output, 1, unit can accept an op this cycle.
REQ-006 SHALL have port alu_out, input, DataWidth, execute result: effective address for load/store, otherwise writeback value.
REQ-007 SHALL have port store_data, input, DataWidth, rs2 value for stores.
REQ-008 SHALL have ports mem_read and mem_write, input, 1 each, load or store op.
REQ-009 SHALL have port funct3, input, 3, access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 SHALL have port rd_in, input, 5, destination register.
REQ-011 SHALL have outputs dmem_req (1), dmem_we (1), dmem_addr (DataWidth, word-aligned), dmem_wdata (DataWidth) and dmem_wmask (4), the data-memory request.
REQ-012 SHALL have inputs dmem_ack (1) and dmem_rdata (DataWidth), the data-memory response.
REQ-013 SHALL have outputs wb_valid (1), wb_rd (5) and wb_data (DataWidth), the writeback result.
REQ-014 SHALL have output access_err (1), a misaligned or illegal access.

Function
REQ-015 SHALL implement FSM states IDLE and ACCESS; ready_out = (state == IDLE).
REQ-016 Accept = valid_in & ready_out; inputs are ignored otherwise.
REQ-017 Accepted non-memory op SHALL produce wb_valid=1, wb_rd=rd_in, wb_data=alu_out in the next cycle (1-cycle latency); state remains IDLE.
REQ-018 mem_read & mem_write together SHALL be handled as a load.
REQ-019 Misaligned access SHALL assert access_err for one cycle after accept, with no dmem_req and no wb_valid. Misaligned means: H/HU with addr[0]=1; W with addr[1:0]!=0; load funct3 in {011,110,111}; store funct3 other than {000,001,010}.
REQ-020 Aligned memory op SHALL move IDLE->ACCESS and register the request; dmem_req=1 from the next cycle.
REQ-021 dmem_addr SHALL be {alu_out[31:2], 2'b00}.
REQ-022 dmem_we SHALL be 1 for stores and 0 for loads.
REQ-023 In ACCESS, dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_wmask SHALL hold stable until dmem_ack=1 is sampled.
REQ-024 On the first dmem_ack=1 in ACCESS: next cycle state=IDLE and dmem_req=0. A load also gives wb_valid=1 with the extended data; a store gives no wb_valid.
REQ-025 dmem_ack in IDLE SHALL be ignored.
REQ-026 Store byte: wmask = 4'b0001 << addr[1:0]; wdata = store_data[7:0] replicated 4x.
REQ-027 Store half: wmask = 4'b0011 << addr[1:0]; wdata = store_data[15:0] replicated 2x.
REQ-028 Store word: wmask = 4'b1111; wdata = store_data.
REQ-029 Loads: dmem_wmask=0. The lane is selected by addr[1:0]. B/H are sign-extended; BU/HU are zero-extended to 32 bits.
REQ-030 wb_valid and access_err SHALL be single-cycle pulses. wb_rd and wb_data are don't-care when wb_valid=0.
REQ-031 At most one op SHALL be outstanding; ready_out=0 stalls upstream for the whole ACCESS state.

Reset
REQ-032 rst=0 SHALL immediately force state=IDLE and dmem_req=dmem_we=wb_valid=access_err=0. It also forces dmem_wmask=0, dmem_addr=dmem_wdata=wb_data=0 and wb_rd=0; ready_out=1 after release.
REQ-033 Reset during ACCESS SHALL abandon the access; a late dmem_ack after release is ignored.

Verification
REQ-034 Non-memory op alu_out=0x0000_1234, rd_in=5 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x0000_1234.
REQ-035 SB addr 0x103, store_data=0xAB -> dmem_addr=0x100, wmask=1000, wdata=0xABABABAB. Ack after 3 cycles -> ready_out returns to 1, no wb_valid.
REQ-036 LB addr 0x202, rdata=0x0080_0000 -> wb_data=0xFFFF_FF80. LBU from the same address -> wb_data=0x0000_0080.
REQ-037 LH addr 0x301 -> access_err pulse, dmem_req stays 0, wb_valid=0, ready_out stays 1.
REQ-038 LW addr 0x400, ack in the first ACCESS cycle, rdata=0xDEADBEEF -> wb_data=0xDEADBEEF. A back-to-back valid_in is accepted the cycle ready_out rises.
REQ-039 rst asserted while dmem_req=1 -> dmem_req=0 immediately; ack pulse after release -> no wb_valid.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding data-memory access per op,
// byte/half/word lanes, load extension, misalignment trap.
module load_store_unit #(
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic [DataWidth-1:0] alu_out,
  input  logic [DataWidth-1:0] store_data,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [2:0]           funct3,
  input  logic [4:0]           rd_in,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [DataWidth-1:0] dmem_addr,
  output logic [DataWidth-1:0] dmem_wdata,
  output logic [3:0]           dmem_wmask,
  input  logic                 dmem_ack,
  input  logic [DataWidth-1:0] dmem_rdata,
  output logic                 wb_valid,
  output logic [4:0]           wb_rd,
  output logic [DataWidth-1:0] wb_data,
  output logic                 access_err
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]           r_state;
  logic                 r_req;
  logic                 r_we;
  logic [DataWidth-1:0] r_addr;
  logic [DataWidth-1:0] r_wdata;
  logic [3:0]           r_wmask;
  logic [1:0]           r_lo;
  logic [2:0]           r_f3;
  logic [4:0]           r_rd;
  logic                 r_wb_valid;
  logic [4:0]           r_wb_rd;
  logic [DataWidth-1:0] r_wb_data;
  logic                 r_err;

  logic                 w_accept;
  logic                 w_mem;
  logic                 w_load;
  logic [1:0]           w_lo;
  logic                 w_misal;
  logic [DataWidth-1:0] w_wdata;
  logic [3:0]           w_wmask;
  logic [DataWidth-1:0] w_sh;
  logic [DataWidth-1:0] w_ld;

  assign ready_out  = (r_state == IDLE);
  assign w_accept   = valid_in & ready_out;
  assign w_mem      = mem_read | mem_write;
  assign w_load     = mem_read;
  assign w_lo       = alu_out[1:0];

  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign dmem_wmask = r_wmask;
  assign wb_valid   = r_wb_valid;
  assign wb_rd      = r_wb_rd;
  assign wb_data    = r_wb_data;
  assign access_err = r_err;

  // Alignment and legal-size check for the incoming memory op
  always_comb begin
    w_misal = 1'b0;
    case (funct3)
      3'b000:         w_misal = 1'b0;
      3'b001:         w_misal = w_lo[0];
      3'b010:         w_misal = |w_lo;
      3'b100:         w_misal = ~w_load;
      3'b101:         w_misal = w_lo[0] | ~w_load;
      default:        w_misal = 1'b1;
    endcase
  end

  // Store lane mask and replicated write data
  always_comb begin
    w_wmask = 4'b0000;
    w_wdata = '0;
    case (funct3[1:0])
      2'b00: begin
        w_wmask = 4'b0001 << w_lo;
        w_wdata = {(DataWidth/8){store_data[7:0]}};
      end
      2'b01: begin
        w_wmask = 4'b0011 << w_lo;
        w_wdata = {(DataWidth/16){store_data[15:0]}};
      end
      default: begin
        w_wmask = 4'b1111;
        w_wdata = store_data;
      end
    endcase
  end

  assign w_sh = dmem_rdata >> {r_lo, 3'b000};

  // Load lane extraction with sign/zero extension
  always_comb begin
    w_ld = w_sh;
    case (r_f3)
      3'b000:  w_ld = {{(DataWidth-8){w_sh[7]}}, w_sh[7:0]};
      3'b001:  w_ld = {{(DataWidth-16){w_sh[15]}}, w_sh[15:0]};
      3'b100:  w_ld = {{(DataWidth-8){1'b0}}, w_sh[7:0]};
      3'b101:  w_ld = {{(DataWidth-16){1'b0}}, w_sh[15:0]};
      default: w_ld = w_sh;
    endcase
  end

  // Control FSM, request registers and writeback pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= 4'b0000;
      r_lo       <= 2'b00;
      r_f3       <= 3'b000;
      r_rd       <= 5'd0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (!w_mem) begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= rd_in;
              r_wb_data  <= alu_out;
            end else if (w_misal) begin
              r_err <= 1'b1;
            end else begin
              r_state <= ACCESS;
              r_req   <= 1'b1;
              r_we    <= ~w_load;
              r_addr  <= {alu_out[DataWidth-1:2], 2'b00};
              r_wdata <= w_load ? '0 : w_wdata;
              r_wmask <= w_load ? 4'b0000 : w_wmask;
              r_lo    <= w_lo;
              r_f3    <= funct3;
              r_rd    <= rd_in;
            end
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_wmask <= 4'b0000;
            if (!r_we) begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= r_rd;
              r_wb_data  <= w_ld;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: vector table plus
// writeback scoreboard and reset/back-to-back sequences.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] alu_out;
  logic [31:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [4:0]  rd_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        access_err;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.DataWidth(32)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .ready_out(ready_out),
    .alu_out(alu_out), .store_data(store_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .rd_in(rd_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wmask(dmem_wmask), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .access_err(access_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [4:0]  rdi;
    logic        err;
    logic [31:0] eaddr;
    logic [3:0]  emask;
    logic [31:0] ewdata;
    logic        wb;
    logic [31:0] ewb;
    int          dly;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  vec_t v[16];
  wb_t  q[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic rd, input logic wr,
    input logic [2:0] f3, input logic [31:0] addr,
    input logic [31:0] sdata, input logic [31:0] rdata,
    input logic [4:0] rdi, input logic err,
    input logic [31:0] eaddr, input logic [3:0] emask,
    input logic [31:0] ewdata, input logic wb,
    input logic [31:0] ewb, input int dly);
    vec_t t;
    t.rd = rd; t.wr = wr; t.f3 = f3;
    t.addr = addr; t.sdata = sdata; t.rdata = rdata;
    t.rdi = rdi; t.err = err; t.eaddr = eaddr;
    t.emask = emask; t.ewdata = ewdata;
    t.wb = wb; t.ewb = ewb; t.dly = dly;
    return t;
  endfunction

  // Scoreboard: every writeback pulse must match the oldest expectation
  always @(posedge clk) begin
    #1;
    if (wb_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb act_rd=%0d act_data=%h exp=none",
                 wb_rd, wb_data);
      end else begin
        wb_t e;
        e = q.pop_front();
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        chk("wb_data", wb_data, e.data);
      end
    end
  end

  task automatic drive(input logic rd, input logic wr,
                       input logic [2:0] f3,
                       input logic [31:0] addr,
                       input logic [31:0] sdata,
                       input logic [4:0] rdi);
    valid_in   = 1'b1;
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    alu_out    = addr;
    store_data = sdata;
    rd_in      = rdi;
  endtask

  task automatic run_vec(input int i);
    vec_t t;
    wb_t  e;
    t = v[i];
    @(negedge clk);
    drive(t.rd, t.wr, t.f3, t.addr, t.sdata, t.rdi);
    if (t.wb) begin
      e.rd = t.rdi;
      e.data = t.ewb;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (t.err) begin
      chk("err_pulse", {31'd0, access_err}, 32'd1);
      chk("err_noreq", {31'd0, dmem_req}, 32'd0);
      chk("err_ready", {31'd0, ready_out}, 32'd1);
      @(negedge clk);
      valid_in = 1'b0;
      @(posedge clk);
      #1;
      chk("err_single", {31'd0, access_err}, 32'd0);
    end else if (t.rd | t.wr) begin
      chk("req", {31'd0, dmem_req}, 32'd1);
      chk("stall", {31'd0, ready_out}, 32'd0);
      chk("addr", dmem_addr, t.eaddr);
      chk("we", {31'd0, dmem_we}, {31'd0, ~t.rd});
      chk("wmask", {28'd0, dmem_wmask}, {28'd0, t.emask});
      if (!t.rd) chk("wdata", dmem_wdata, t.ewdata);
      @(negedge clk);
      valid_in = 1'b0;
      for (int k = 0; k < t.dly; k++) begin
        @(posedge clk);
        #1;
        chk("req_hold", {31'd0, dmem_req}, 32'd1);
        chk("addr_hold", dmem_addr, t.eaddr);
        chk("stall_hold", {31'd0, ready_out}, 32'd0);
      end
      @(negedge clk);
      dmem_ack   = 1'b1;
      dmem_rdata = t.rdata;
      @(posedge clk);
      #1;
      chk("req_drop", {31'd0, dmem_req}, 32'd0);
      chk("ready_back", {31'd0, ready_out}, 32'd1);
      @(negedge clk);
      dmem_ack = 1'b0;
    end else begin
      chk("nm_ready", {31'd0, ready_out}, 32'd1);
      chk("nm_noreq", {31'd0, dmem_req}, 32'd0);
      @(negedge clk);
      valid_in = 1'b0;
    end
  endtask

  initial begin
    wb_t e;
    v[0]  = mk(0,0,3'b000,32'h0000_1234,32'h0,32'h0,5'd5,0,
               32'h0,4'h0,32'h0,1,32'h0000_1234,0);
    v[1]  = mk(0,1,3'b000,32'h0000_0103,32'h0000_00AB,32'h0,5'd6,0,
               32'h0000_0100,4'b1000,32'hABAB_ABAB,0,32'h0,3);
    v[2]  = mk(1,0,3'b000,32'h0000_0202,32'h0,32'h0080_0000,5'd7,0,
               32'h0000_0200,4'h0,32'h0,1,32'hFFFF_FF80,1);
    v[3]  = mk(1,0,3'b100,32'h0000_0202,32'h0,32'h0080_0000,5'd8,0,
               32'h0000_0200,4'h0,32'h0,1,32'h0000_0080,2);
    v[4]  = mk(1,0,3'b001,32'h0000_0301,32'h0,32'h0,5'd9,1,
               32'h0,4'h0,32'h0,0,32'h0,0);
    v[5]  = mk(1,0,3'b010,32'h0000_0400,32'h0,32'hDEAD_BEEF,5'd10,0,
               32'h0000_0400,4'h0,32'h0,1,32'hDEAD_BEEF,0);
    v[6]  = mk(0,1,3'b001,32'h0000_0206,32'h1234_5678,32'h0,5'd11,0,
               32'h0000_0204,4'b1100,32'h5678_5678,0,32'h0,1);
    v[7]  = mk(0,1,3'b010,32'h0000_0010,32'hCAFE_F00D,32'h0,5'd12,0,
               32'h0000_0010,4'b1111,32'hCAFE_F00D,0,32'h0,2);
    v[8]  = mk(1,0,3'b101,32'h0000_0502,32'h0,32'h8765_4321,5'd13,0,
               32'h0000_0500,4'h0,32'h0,1,32'h0000_8765,0);
    v[9]  = mk(1,0,3'b001,32'h0000_0502,32'h0,32'h8765_4321,5'd14,0,
               32'h0000_0500,4'h0,32'h0,1,32'hFFFF_8765,1);
    v[10] = mk(1,0,3'b010,32'h0000_0402,32'h0,32'h0,5'd15,1,
               32'h0,4'h0,32'h0,0,32'h0,0);
    v[11] = mk(1,0,3'b011,32'h0000_0000,32'h0,32'h0,5'd16,1,
               32'h0,4'h0,32'h0,0,32'h0,0);
    v[12] = mk(0,1,3'b100,32'h0000_0000,32'h0,32'h0,5'd17,1,
               32'h0,4'h0,32'h0,0,32'h0,0);
    v[13] = mk(1,1,3'b010,32'h0000_0600,32'h5555_5555,32'h1122_3344,
               5'd18,0,32'h0000_0600,4'h0,32'h0,1,32'h1122_3344,2);
    v[14] = mk(0,1,3'b001,32'h0000_0101,32'h0,32'h0,5'd19,1,
               32'h0,4'h0,32'h0,0,32'h0,0);
    v[15] = mk(1,0,3'b000,32'h0000_0003,32'h0,32'h7F00_0000,5'd20,0,
               32'h0000_0000,4'h0,32'h0,1,32'h0000_007F,3);

    rst = 1'b0;
    valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b000; alu_out = 32'h0; store_data = 32'h0;
    rd_in = 5'd0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
    chk("rst_err", {31'd0, access_err}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wmask", {28'd0, dmem_wmask}, 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready_out}, 32'd1);

    // Ack while idle must be ignored
    @(negedge clk);
    dmem_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_ack_req", {31'd0, dmem_req}, 32'd0);
    chk("idle_ack_rdy", {31'd0, ready_out}, 32'd1);
    @(negedge clk);
    dmem_ack = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(i);

    // LW acked in its first ACCESS cycle, next op waiting upstream
    @(negedge clk);
    drive(1, 0, 3'b010, 32'h0000_0400, 32'h0, 5'd21);
    e.rd = 5'd21; e.data = 32'hDEAD_BEEF;
    q.push_back(e);
    @(posedge clk);
    #1;
    chk("b2b_req", {31'd0, dmem_req}, 32'd1);
    @(negedge clk);
    drive(0, 0, 3'b000, 32'h0000_0777, 32'h0, 5'd22);
    e.rd = 5'd22; e.data = 32'h0000_0777;
    q.push_back(e);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    chk("b2b_ready", {31'd0, ready_out}, 32'd1);
    @(negedge clk);
    dmem_ack = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b_accept", {31'd0, wb_valid}, 32'd1);
    @(negedge clk);
    valid_in = 1'b0;

    // Reset in the middle of an access
    @(negedge clk);
    drive(1, 0, 3'b010, 32'h0000_0700, 32'h0, 5'd23);
    @(posedge clk);
    #1;
    chk("rstacc_req", {31'd0, dmem_req}, 32'd1);
    @(negedge clk);
    valid_in = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("rstacc_drop", {31'd0, dmem_req}, 32'd0);
    chk("rstacc_rdy", {31'd0, ready_out}, 32'd1);
    chk("rstacc_mask", {28'd0, dmem_wmask}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    chk("late_ack_req", {31'd0, dmem_req}, 32'd0);
    chk("late_ack_rdy", {31'd0, ready_out}, 32'd1);
    @(negedge clk);
    dmem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("sb_empty", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
